// File: rtl/guess_pkg.sv
// Shared types and helpers for the guess-entry front end.
// Optional build macro used by guess_entry: DUP_REJECT_EN.
package guess_pkg;

    localparam int NUM_PEGS = 4;

    typedef logic [2:0] peg_t;

    localparam peg_t COLOR_OFF = 3'd0;
    localparam peg_t COLOR_MIN = 3'd1;

    typedef enum logic [0:0] {
        GUESS   = 1'b0,
        HISTORY = 1'b1
    } state_t;

    // Packed as {g3, g2, g1, g0}
    typedef peg_t [NUM_PEGS-1:0] guess_t;

    function automatic peg_t peg_next(input peg_t p, input int unsigned num_colors);
        return (p >= peg_t'(num_colors)) ? COLOR_MIN : p + 3'd1;
    endfunction

    function automatic peg_t peg_prev(input peg_t p, input int unsigned num_colors);
        return (p <= COLOR_MIN) ? peg_t'(num_colors) : p - 3'd1;
    endfunction

endpackage

// File: rtl/guess_entry_if.sv
// Button inputs and LED/submit outputs of the guess-entry controller.
// master drives the buttons, slave is the controller itself.
interface guess_entry_if #(
    parameter int HIST_DEPTH = 8
);
    import guess_pkg::*;

    logic btn_left;
    logic btn_right;
    logic btn_up;
    logic btn_down;
    logic btn_submit;
    logic btn_mode;

    logic                        blink_enable;
    logic [1:0]                  blink_led;
    peg_t                        guess_rgb0;
    peg_t                        guess_rgb1;
    peg_t                        guess_rgb2;
    peg_t                        guess_rgb3;
    peg_t                        history_rgb0;
    peg_t                        history_rgb1;
    peg_t                        history_rgb2;
    peg_t                        history_rgb3;
    logic                        submit_valid;
    guess_t                      submit_guess;
    logic                        submit_reject;
    logic [$clog2(HIST_DEPTH):0] hist_count;

    modport master (
        output btn_left, btn_right, btn_up, btn_down, btn_submit, btn_mode,
        input  blink_enable, blink_led,
        input  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3,
        input  history_rgb0, history_rgb1, history_rgb2, history_rgb3,
        input  submit_valid, submit_guess, submit_reject, hist_count
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, btn_submit, btn_mode,
        output blink_enable, blink_led,
        output guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3,
        output history_rgb0, history_rgb1, history_rgb2, history_rgb3,
        output submit_valid, submit_guess, submit_reject, hist_count
    );

endinterface

// File: rtl/guess_history_buf.sv
// Ring buffer of submitted guesses with a saturating count and a read-by-age port.
// Age 0 is the newest entry; the read data is registered (one cycle latency).
module guess_history_buf
    import guess_pkg::*;
#(
    parameter int HIST_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  guess_t                      push_data,
    input  logic [$clog2(HIST_DEPTH)-1:0] rd_age,
    output guess_t                      rd_data,
`ifdef DUP_REJECT_EN
    output guess_t                      newest,
`endif
    output logic [$clog2(HIST_DEPTH):0] count
);
    localparam int IW = $clog2(HIST_DEPTH);
    localparam int CW = IW + 1;

    guess_t          mem [HIST_DEPTH];
    logic [IW-1:0]   wptr_reg;
    logic [CW-1:0]   count_reg;
    logic [IW-1:0]   rd_addr;
    guess_t          rd_data_reg;

    // Storage carries no reset; an empty buffer is masked at the read register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg  <= '0;
            count_reg <= '0;
        end else if (push) begin
            wptr_reg <= wptr_reg + IW'(1);
            if (count_reg != CW'(HIST_DEPTH)) begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign rd_addr = wptr_reg - IW'(1) - rd_age;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (count_reg == '0) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

`ifdef DUP_REJECT_EN
    // Shadow copy of the newest entry so the duplicate test needs no RAM read.
    guess_t newest_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            newest_reg <= '0;
        end else if (push) begin
            newest_reg <= push_data;
        end
    end

    assign newest = newest_reg;
`endif

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/guess_entry.sv
// Guess-entry front end: button FSM, cursor, peg colours and history browsing.
// Define DUP_REJECT_EN to reject a submit that repeats the newest history entry.
module guess_entry
    import guess_pkg::*;
#(
    parameter int NUM_COLORS = 6,
    parameter int HIST_DEPTH = 8
) (
    input logic          clk,
    input logic          rst,
    guess_entry_if.slave bus
);
    localparam int IW = $clog2(HIST_DEPTH);
    localparam int CW = IW + 1;

    localparam logic [0:0] S_GUESS   = GUESS;
    localparam logic [0:0] S_HISTORY = HISTORY;

    logic [0:0]    state_reg;
    logic [1:0]    cursor_reg;
    logic [IW-1:0] index_reg;
    logic          submit_valid_reg;
    guess_t        submit_guess_reg;
    guess_t        cur_guess;
    guess_t        hist_data;
    logic [CW-1:0] hist_count;
    logic          push;
    logic          dup;
    logic          in_guess;

    logic act_mode;
    logic act_submit;
    logic act_up;
    logic act_down;
    logic act_left;
    logic act_right;

    // Only the highest-priority pulse survives.
    always_comb begin
        act_mode   = 1'b0;
        act_submit = 1'b0;
        act_up     = 1'b0;
        act_down   = 1'b0;
        act_left   = 1'b0;
        act_right  = 1'b0;
        if (bus.btn_mode) begin
            act_mode = 1'b1;
        end else if (bus.btn_submit) begin
            act_submit = 1'b1;
        end else if (bus.btn_up) begin
            act_up = 1'b1;
        end else if (bus.btn_down) begin
            act_down = 1'b1;
        end else if (bus.btn_left) begin
            act_left = 1'b1;
        end else if (bus.btn_right) begin
            act_right = 1'b1;
        end
    end

    assign in_guess = (state_reg == S_GUESS);
    assign push     = in_guess && act_submit && !dup;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PEGS; gi++) begin : g_peg
            peg_t peg_reg;
            logic sel;

            assign sel = in_guess && (cursor_reg == 2'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    peg_reg <= COLOR_MIN;
                end else if (sel && act_up) begin
                    peg_reg <= peg_next(peg_reg, NUM_COLORS);
                end else if (sel && act_down) begin
                    peg_reg <= peg_prev(peg_reg, NUM_COLORS);
                end
            end

            assign cur_guess[gi] = peg_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_GUESS;
            cursor_reg       <= 2'd0;
            index_reg        <= '0;
            submit_valid_reg <= 1'b0;
            submit_guess_reg <= '0;
        end else begin
            submit_valid_reg <= 1'b0;
            if (in_guess) begin
                if (act_mode) begin
                    if (hist_count != '0) begin
                        state_reg <= S_HISTORY;
                        index_reg <= '0;
                    end
                end else if (push) begin
                    submit_valid_reg <= 1'b1;
                    submit_guess_reg <= cur_guess;
                    cursor_reg       <= 2'd0;
                end else if (act_left) begin
                    cursor_reg <= cursor_reg - 2'd1;
                end else if (act_right) begin
                    cursor_reg <= cursor_reg + 2'd1;
                end
            end else begin
                if (act_mode) begin
                    state_reg <= S_GUESS;
                end else if (act_up) begin
                    if (CW'(index_reg) + CW'(1) < hist_count) begin
                        index_reg <= index_reg + IW'(1);
                    end
                end else if (act_down) begin
                    if (index_reg != '0) begin
                        index_reg <= index_reg - IW'(1);
                    end
                end
            end
        end
    end

`ifdef DUP_REJECT_EN
    guess_t newest;
    logic   submit_reject_reg;

    assign dup = (hist_count != '0) && (cur_guess == newest);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            submit_reject_reg <= 1'b0;
        end else begin
            submit_reject_reg <= in_guess && act_submit && dup;
        end
    end

    assign bus.submit_reject = submit_reject_reg;
`else
    assign dup               = 1'b0;
    assign bus.submit_reject = 1'b0;
`endif

    guess_history_buf #(
        .HIST_DEPTH(HIST_DEPTH)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cur_guess),
        .rd_age    (index_reg),
        .rd_data   (hist_data),
`ifdef DUP_REJECT_EN
        .newest    (newest),
`endif
        .count     (hist_count)
    );

    assign bus.blink_enable = in_guess;
    assign bus.blink_led    = cursor_reg;
    assign bus.guess_rgb0   = cur_guess[0];
    assign bus.guess_rgb1   = cur_guess[1];
    assign bus.guess_rgb2   = cur_guess[2];
    assign bus.guess_rgb3   = cur_guess[3];
    assign bus.history_rgb0 = hist_data[0];
    assign bus.history_rgb1 = hist_data[1];
    assign bus.history_rgb2 = hist_data[2];
    assign bus.history_rgb3 = hist_data[3];
    assign bus.submit_valid = submit_valid_reg;
    assign bus.submit_guess = submit_guess_reg;
    assign bus.hist_count   = hist_count;

endmodule

// File: tb/tb_guess_entry.sv
// Randomised and directed bench for guess_entry against a list-based game model.
module tb_guess_entry;
    import guess_pkg::*;

    localparam int NC = 6;
    localparam int HD = 8;
    localparam int CW = $clog2(HD) + 1;

    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_MODE  = 6'b100000;
    localparam logic [5:0] B_SUB   = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    guess_entry_if #(.HIST_DEPTH(HD)) bus ();

    guess_entry #(
        .NUM_COLORS(NC),
        .HIST_DEPTH(HD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    // Game model: history list has the newest guess at position 0.
    bit          m_hist;
    int          m_cur;
    int          m_peg [4];
    logic [11:0] m_hq [$];
    int          m_idx;
    bit          m_sv;
    bit          m_sr;
    logic [11:0] m_sg;
    logic [11:0] m_hshow;
    logic [11:0] sub_log [$];

    function automatic logic [11:0] m_guess();
        return {3'(m_peg[3]), 3'(m_peg[2]), 3'(m_peg[1]), 3'(m_peg[0])};
    endfunction

    function automatic void m_reset();
        m_hist = 0;
        m_cur  = 0;
        for (int i = 0; i < 4; i++) m_peg[i] = 1;
        m_hq.delete();
        m_idx   = 0;
        m_sv    = 0;
        m_sr    = 0;
        m_sg    = '0;
        m_hshow = '0;
    endfunction

    function automatic void m_apply(input logic [5:0] b);
        logic [11:0] shown;
        logic [11:0] g;
        bit          is_dup;
        shown = (m_hq.size() == 0) ? 12'd0 : m_hq[m_idx];
        m_sv  = 0;
        m_sr  = 0;
        if (b[5]) begin
            if (m_hist) m_hist = 0;
            else if (m_hq.size() > 0) begin
                m_hist = 1;
                m_idx  = 0;
            end
        end else if (b[4]) begin
            if (!m_hist) begin
                g = m_guess();
`ifdef DUP_REJECT_EN
                is_dup = (m_hq.size() > 0) && (m_hq[0] == g);
`else
                is_dup = 0;
`endif
                if (is_dup) m_sr = 1;
                else begin
                    m_hq.push_front(g);
                    if (m_hq.size() > HD) void'(m_hq.pop_back());
                    m_sv  = 1;
                    m_sg  = g;
                    m_cur = 0;
                    sub_log.push_back(g);
                end
            end
        end else if (b[3]) begin
            if (!m_hist) m_peg[m_cur] = (m_peg[m_cur] == NC) ? 1 : m_peg[m_cur] + 1;
            else if (m_idx < m_hq.size() - 1) m_idx++;
        end else if (b[2]) begin
            if (!m_hist) m_peg[m_cur] = (m_peg[m_cur] == 1) ? NC : m_peg[m_cur] - 1;
            else if (m_idx > 0) m_idx--;
        end else if (b[1]) begin
            if (!m_hist) m_cur = (m_cur + 3) % 4;
        end else if (b[0]) begin
            if (!m_hist) m_cur = (m_cur + 1) % 4;
        end
        m_hshow = shown;
    endfunction

    function automatic logic [63:0] observed();
        return 64'({bus.blink_enable, bus.blink_led,
                    bus.guess_rgb3, bus.guess_rgb2, bus.guess_rgb1, bus.guess_rgb0,
                    bus.history_rgb3, bus.history_rgb2, bus.history_rgb1, bus.history_rgb0,
                    bus.submit_valid, bus.submit_guess, bus.submit_reject, bus.hist_count});
    endfunction

    function automatic logic [63:0] expected();
        return 64'({~m_hist, 2'(m_cur), m_guess(), m_hshow,
                    m_sv, m_sg, m_sr, CW'(m_hq.size())});
    endfunction

    task automatic set_btns(input logic [5:0] b);
        {bus.btn_mode, bus.btn_submit, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
    endtask

    task automatic step(input logic [5:0] b);
        @(negedge clk);
        set_btns(b);
        @(posedge clk);
        #1;
        set_btns(B_NONE);
        m_apply(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_btns(B_NONE);
        rst = 1'b1;
        m_reset();
        sub_log.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (observed() !== expected())
            $display("FAIL reset_state: got %h want %h", observed(), expected());
        else passed++;
    endtask

    task automatic test_cursor();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(i < 5 ? B_RIGHT : B_LEFT);
            total++;
            if (observed() !== expected())
                $display("FAIL cursor_step%0d: got %h want %h", i, observed(), expected());
            else passed++;
            if (i == 4) begin
                total++;
                if (bus.blink_led !== 2'd1)
                    $display("FAIL cursor_right_wrap: got %0d want 1", bus.blink_led);
                else passed++;
            end
        end
        total++;
        if (bus.blink_led !== 2'd3)
            $display("FAIL cursor_left_wrap: got %0d want 3", bus.blink_led);
        else passed++;
    endtask

    task automatic test_colour();
        do_reset();
        for (int i = 0; i < 6; i++) step(B_UP);
        total++;
        if (bus.guess_rgb0 !== 3'd1)
            $display("FAIL colour_up_wrap: got %0d want 1", bus.guess_rgb0);
        else passed++;
        step(B_DOWN);
        total++;
        if (bus.guess_rgb0 !== 3'd6)
            $display("FAIL colour_down_wrap: got %0d want 6", bus.guess_rgb0);
        else passed++;
        total++;
        if (observed() !== expected())
            $display("FAIL colour_state: got %h want %h", observed(), expected());
        else passed++;
    endtask

    task automatic test_submit();
        logic [5:0] seq [14] = '{B_UP, B_RIGHT, B_UP, B_UP, B_RIGHT, B_UP, B_UP, B_UP,
                                 B_RIGHT, B_UP, B_UP, B_UP, B_UP, B_SUB};
        do_reset();
        foreach (seq[i]) step(seq[i]);
        total++;
        if ({bus.submit_valid, bus.submit_guess, bus.hist_count, bus.blink_led} !== {1'b1, 12'o5432, CW'(1), 2'd0})
            $display("FAIL submit_pulse: got v=%0b g=%o n=%0d c=%0d want v=1 g=5432 n=1 c=0",
                     bus.submit_valid, bus.submit_guess, bus.hist_count, bus.blink_led);
        else passed++;
        step(B_NONE);
        total++;
        if (bus.submit_valid !== 1'b0)
            $display("FAIL submit_one_cycle: got %0b want 0", bus.submit_valid);
        else passed++;
        step(B_MODE);
        step(B_NONE);
        total++;
        if ({bus.blink_enable, bus.history_rgb3, bus.history_rgb2, bus.history_rgb1, bus.history_rgb0}
            !== {1'b0, 3'd5, 3'd4, 3'd3, 3'd2})
            $display("FAIL history_view: got be=%0b h=%0d%0d%0d%0d want be=0 h=5432", bus.blink_enable,
                     bus.history_rgb3, bus.history_rgb2, bus.history_rgb1, bus.history_rgb0);
        else passed++;
    endtask

    task automatic test_fill();
        do_reset();
        step(B_MODE);
        total++;
        if (bus.blink_enable !== 1'b1)
            $display("FAIL mode_empty: got %0b want 1", bus.blink_enable);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            step(B_UP);
            if (i % 3 == 0) begin
                step(B_RIGHT);
                step(B_UP);
                step(B_LEFT);
            end
            step(B_SUB);
            total++;
            if (observed() !== expected())
                $display("FAIL fill_submit%0d: got %h want %h", i, observed(), expected());
            else passed++;
        end
        total++;
        if (bus.hist_count !== CW'(HD))
            $display("FAIL fill_count: got %0d want %0d", bus.hist_count, HD);
        else passed++;
        step(B_MODE);
        for (int i = 0; i < 9; i++) step(B_UP);
        step(B_NONE);
        total++;
        if ({bus.history_rgb3, bus.history_rgb2, bus.history_rgb1, bus.history_rgb0} !== sub_log[2])
            $display("FAIL fill_oldest: got %o want %o",
                     {bus.history_rgb3, bus.history_rgb2, bus.history_rgb1, bus.history_rgb0}, sub_log[2]);
        else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        step(B_UP);
        step(B_SUB);
        step(B_MODE | B_SUB);
        total++;
        if ({bus.blink_enable, bus.submit_valid, bus.hist_count} !== {1'b0, 1'b0, CW'(1)})
            $display("FAIL prio_mode_submit: got be=%0b v=%0b n=%0d want be=0 v=0 n=1",
                     bus.blink_enable, bus.submit_valid, bus.hist_count);
        else passed++;
        step(B_UP | B_LEFT);
        total++;
        if (observed() !== expected())
            $display("FAIL prio_history: got %h want %h", observed(), expected());
        else passed++;
        // Reset pulse placed between clock edges must act without a clock.
        @(negedge clk);
        #1 rst = 1'b1;
        m_reset();
        #1;
        total++;
        if (observed() !== expected())
            $display("FAIL async_reset: got %h want %h", observed(), expected());
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        step(B_NONE);
        total++;
        if (observed() !== expected())
            $display("FAIL after_reset: got %h want %h", observed(), expected());
        else passed++;
    endtask

    task automatic test_dup();
        do_reset();
        step(B_DOWN);
        step(B_SUB);
        step(B_SUB);
`ifdef DUP_REJECT_EN
        total++;
        if ({bus.submit_reject, bus.submit_valid, bus.hist_count} !== {1'b1, 1'b0, CW'(1)})
            $display("FAIL dup_reject: got r=%0b v=%0b n=%0d want r=1 v=0 n=1",
                     bus.submit_reject, bus.submit_valid, bus.hist_count);
        else passed++;
`else
        total++;
        if ({bus.submit_reject, bus.submit_valid, bus.hist_count} !== {1'b0, 1'b1, CW'(2)})
            $display("FAIL dup_accept: got r=%0b v=%0b n=%0d want r=0 v=1 n=2",
                     bus.submit_reject, bus.submit_valid, bus.hist_count);
        else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(B_SUB);
            total++;
            if (observed() !== expected())
                $display("FAIL b2b_submit%0d: got %h want %h", i, observed(), expected());
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [5:0] pick [7] = '{B_MODE, B_SUB, B_UP, B_DOWN, B_LEFT, B_RIGHT, B_NONE};
        logic [5:0] b;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            b = pick[$urandom_range(0, 6)];
            step(b);
            total++;
            if (observed() !== expected())
                $display("FAIL random_step%0d btn=%b: got %h want %h", i, b, observed(), expected());
            else passed++;
        end
    endtask

    initial begin
        set_btns(B_NONE);
        m_reset();
        test_reset();
        test_cursor();
        test_colour();
        test_submit();
        test_fill();
        test_priority();
        test_dup();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
